// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared PCI command codes, bus levels and initiator state enum
package pci_pkg;
  localparam logic [3:0] PCI_READ  = 4'b0010;
  localparam logic [3:0] PCI_WRITE = 4'b0011;

  // FRAME#, IRDY#, DEVSEL# and TRDY# are all active-low
  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    ABORT = 3'd3,
    TURN  = 3'd4
  } pci_state_t;
endpackage

// File: rtl/pci_initiator.sv
// rtl/pci_initiator.sv - single-burst PCI bus master with wait states and master abort
module pci_initiator
  import pci_pkg::*;
#(
  parameter int TARGET_TIMEOUT = 5,
  parameter int MAX_BURST      = 4
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   req,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [1:0]             req_len,
  input  logic [4*MAX_BURST-1:0] req_be,
  input  logic [32*MAX_BURST-1:0] req_wdata,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   abort,
  output logic                   Frame,
  output logic                   IRDY,
  output logic [3:0]             CBE,
  inout  wire  [31:0]            AD,
  input  logic                   DEVSEL,
  input  logic                   TRDY
);
  localparam int TW = $clog2(TARGET_TIMEOUT + 1);

  pci_state_t              state, nstate;
  logic                    write_q;
  logic [31:0]             addr_q;
  logic [1:0]              len_q;
  logic [4*MAX_BURST-1:0]  be_q;
  logic [32*MAX_BURST-1:0] wdata_q;
  logic [1:0]              phase;
  logic [TW-1:0]           tcnt;
  logic                    devsel_seen;

  logic        complete, timeout, last_phase;
  logic [3:0]  cur_be;
  logic [31:0] cur_wd;
  logic        frame_v, irdy_v, ad_oe, cbe_oe;
  logic [31:0] ad_v;
  logic [3:0]  cbe_v;

  assign last_phase = (phase == len_q);
  assign cur_be     = be_q[{phase, 2'b00} +: 4];
  assign cur_wd     = wdata_q[{phase, 5'b00000} +: 32];
  assign complete   = (state == DATA) && (TRDY == ASSERTED);
  // a completing phase always beats a timeout landing on the same edge
  assign timeout    = (state == DATA) && !complete && (DEVSEL == DEASSERTED) &&
                      !devsel_seen && (tcnt >= TW'(TARGET_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (req) nstate = ADDR;
      ADDR:    nstate = DATA;
      DATA: begin
        if (complete && last_phase) nstate = TURN;
        else if (timeout)           nstate = ABORT;
      end
      ABORT:   nstate = TURN;
      TURN:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    frame_v = DEASSERTED;
    irdy_v  = DEASSERTED;
    ad_oe   = 1'b0;
    ad_v    = '0;
    cbe_oe  = 1'b0;
    cbe_v   = '0;
    case (state)
      ADDR: begin
        frame_v = ASSERTED;
        ad_oe   = 1'b1;
        ad_v    = addr_q;
        cbe_oe  = 1'b1;
        cbe_v   = write_q ? PCI_WRITE : PCI_READ;
      end
      DATA: begin
        // releasing FRAME# while IRDY# is low marks the final phase
        frame_v = last_phase ? DEASSERTED : ASSERTED;
        irdy_v  = ASSERTED;
        cbe_oe  = 1'b1;
        cbe_v   = cur_be;
        ad_oe   = write_q;
        ad_v    = cur_wd;
      end
      ABORT: begin
        irdy_v = ASSERTED;
        cbe_oe = 1'b1;
        cbe_v  = cur_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      phase       <= '0;
      tcnt        <= '0;
      devsel_seen <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
      case (state)
        IDLE: if (req) begin
          write_q <= req_write;
          addr_q  <= req_addr;
          len_q   <= req_len;
          be_q    <= req_be;
          wdata_q <= req_wdata;
          phase   <= '0;
        end
        ADDR: begin
          tcnt        <= '0;
          devsel_seen <= 1'b0;
        end
        DATA: begin
          if (DEVSEL == ASSERTED) devsel_seen <= 1'b1;
          if (!devsel_seen && tcnt != TW'(TARGET_TIMEOUT)) tcnt <= tcnt + 1'b1;
          if (complete) begin
            if (!write_q) begin
              rd_data  <= AD;
              rd_valid <= 1'b1;
            end
            if (last_phase) done <= 1'b1;
            else            phase <= phase + 1'b1;
          end else if (timeout) begin
            abort <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Frame = frame_v;
  assign IRDY  = irdy_v;
  assign busy  = (state != IDLE);
  assign CBE   = cbe_oe ? cbe_v : 4'bzzzz;
  assign AD    = ad_oe ? ad_v : 32'bz;
endmodule

// File: tb/tb_pci_initiator.sv
// tb/tb_pci_initiator.sv - randomized bench for pci_initiator with scripted target and trace model
module tb_pci_initiator;
  localparam int TO = 5;
  localparam logic [31:0] ZAD = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         req = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [1:0]   req_len = '0;
  logic [15:0]  req_be = '0;
  logic [127:0] req_wdata = '0;
  logic         DEVSEL = 1'b1;
  logic         TRDY = 1'b1;
  logic         tgt_oe = 1'b0;
  logic [31:0]  tgt_ad = '0;
  wire  [31:0]  rd_data;
  wire          rd_valid, busy, done, abort, Frame, IRDY;
  wire  [3:0]   CBE;
  wire  [31:0]  AD;

  assign AD = tgt_oe ? tgt_ad : 32'bz;
  for (genvar g = 0; g < 32; g++) begin : g_pu_ad
    pullup (AD[g]);
  end
  for (genvar g = 0; g < 4; g++) begin : g_pu_cbe
    pullup (CBE[g]);
  end

  pci_initiator #(.TARGET_TIMEOUT(TO), .MAX_BURST(4)) dut (
    .clk(clk), .RST(RST), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_be(req_be), .req_wdata(req_wdata), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .abort(abort), .Frame(Frame),
    .IRDY(IRDY), .CBE(CBE), .AD(AD), .DEVSEL(DEVSEL), .TRDY(TRDY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 idle, 1 addr, 2 data, 3 abort, 4 turn
    bit          frame, irdy, busy, done, abort, rdv;
    logic [31:0] rdata;
    bit          ad_chk;
    logic [31:0] ad;
    bit          cbe_chk;
    logic [3:0]  cbe;
  } exp_t;

  exp_t        exp_map [int];
  exp_t        ce;
  int          n_vec = 0, n_err = 0;
  bit          chk_en = 1'b0;
  int          obs_busy, obs_rdv, obs_done, obs_abort;
  logic [31:0] rd_obs [$];
  bit          dev_s [80];
  bit          trdy_s [80];
  logic [31:0] mmem [4];
  logic [31:0] tgt_mem [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  function automatic exp_t blank(input int kind, input bit bsy);
    exp_t e;
    e.kind = kind; e.frame = 1'b1; e.irdy = 1'b1; e.busy = bsy;
    e.done = 1'b0; e.abort = 1'b0; e.rdv = 1'b0; e.rdata = '0;
    e.ad_chk = 1'b1; e.ad = ZAD; e.cbe_chk = 1'b1; e.cbe = 4'hF;
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_map.exists(cyc)) begin
        ce = exp_map[cyc];
        exp_map.delete(cyc);
      end else begin
        ce = blank(0, 1'b0);
      end
      chk("Frame", 32'(Frame), 32'(ce.frame));
      chk("IRDY", 32'(IRDY), 32'(ce.irdy));
      chk("busy", 32'(busy), 32'(ce.busy));
      chk("done", 32'(done), 32'(ce.done));
      chk("abort", 32'(abort), 32'(ce.abort));
      chk("rd_valid", 32'(rd_valid), 32'(ce.rdv));
      if (ce.rdv) chk("rd_data", rd_data, ce.rdata);
      if (ce.ad_chk) chk("AD", AD, ce.ad);
      if (ce.cbe_chk) chk("CBE", 32'(CBE), 32'(ce.cbe));
      if (busy === 1'b1) obs_busy++;
      if (done === 1'b1) obs_done++;
      if (abort === 1'b1) obs_abort++;
      if (rd_valid === 1'b1) begin
        obs_rdv++;
        rd_obs.push_back(rd_data);
      end
    end
  end

  task automatic clear_obs();
    obs_busy = 0; obs_rdv = 0; obs_done = 0; obs_abort = 0;
    rd_obs.delete();
  endtask

  // Called one step after a posedge in an idle cycle; returns likewise.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input int len,
                         input logic [15:0] be, input logic [127:0] wd, input int dl,
                         input logic [15:0] waits, input int force_k, input int rst_at,
                         input bit noise);
    bit   present = (addr >= 32'h10) && (addr < 32'h20);
    int   widx = int'(addr[3:2]);
    int   w [4];
    int   kk, p, k, a, tph;
    bit   seen, fin, ended_abort, pend_rdv;
    logic [31:0] pend_rdata;
    exp_t q [$];
    exp_t r;

    for (int i = 0; i < 4; i++) w[i] = int'(waits[4*i +: 4]);
    if (!wr && w[0] < 1) w[0] = 1;
    if (w[0] < dl) w[0] = dl;
    for (int i = 0; i < 80; i++) begin
      dev_s[i] = 1'b1;
      trdy_s[i] = 1'b1;
    end
    if (present) begin
      for (int i = dl + 1; i < 80; i++) dev_s[i] = 1'b0;
      kk = 1;
      for (int i = 0; i <= len; i++) begin
        kk += w[i];
        trdy_s[kk] = 1'b0;
        kk++;
      end
    end
    if (force_k > 0) trdy_s[force_k] = 1'b0;

    // expected trace: address phase, data cycles per the target script, then ABORT/TURN
    r = blank(1, 1'b1);
    r.frame = 1'b0; r.ad = addr; r.cbe = wr ? 4'b0011 : 4'b0010;
    q.push_back(r);
    p = 0; k = 1; seen = 0; fin = 0; ended_abort = 0; pend_rdv = 0; pend_rdata = '0;
    while (!fin) begin
      r = blank(2, 1'b1);
      r.rdv = pend_rdv; r.rdata = pend_rdata; pend_rdv = 0;
      r.frame = (p == len); r.irdy = 1'b0; r.cbe = be[4*p +: 4];
      if (wr) r.ad = wd[32*p +: 32];
      else if (present && k >= 2) r.ad_chk = 1'b0;
      q.push_back(r);
      if (k == rst_at) break;
      if (!dev_s[k]) seen = 1;
      if (!trdy_s[k]) begin
        if (wr && present) begin
          for (int b = 0; b < 4; b++)
            if (!be[4*p + b]) mmem[(widx + p) % 4][8*b +: 8] = wd[32*p + 8*b +: 8];
        end else if (!wr) begin
          pend_rdv = 1; pend_rdata = mmem[(widx + p) % 4];
        end
        if (p == len) fin = 1;
        else p++;
      end else if (!seen && k >= TO) begin
        fin = 1; ended_abort = 1;
      end
      k++;
    end
    if (fin) begin
      if (ended_abort) begin
        r = blank(3, 1'b1);
        r.irdy = 1'b0; r.abort = 1'b1; r.cbe_chk = 1'b0;
        q.push_back(r);
        q.push_back(blank(4, 1'b1));
      end else begin
        r = blank(4, 1'b1);
        r.done = 1'b1; r.rdv = pend_rdv; r.rdata = pend_rdata;
        q.push_back(r);
      end
    end

    req = 1'b1; req_write = wr; req_addr = addr; req_len = 2'(len);
    req_be = be; req_wdata = wd;
    a = cyc + 1;
    foreach (q[i]) exp_map[a + i] = q[i];
    tph = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      req = noise ? 1'($urandom % 2) : 1'b0;
      if (noise) begin
        req_write = 1'($urandom % 2); req_addr = $urandom; req_len = 2'($urandom % 4);
        req_be = 16'($urandom); req_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      RST = (i == rst_at);
      if (q[i].kind == 2) begin
        DEVSEL = dev_s[i];
        TRDY = trdy_s[i];
        tgt_oe = present && !wr && (i >= 2);
        tgt_ad = tgt_mem[(widx + tph) % 4];
        if (present && IRDY === 1'b0 && !trdy_s[i] && !RST) begin
          if (wr)
            for (int b = 0; b < 4; b++)
              if (CBE[b] === 1'b0) tgt_mem[(widx + tph) % 4][8*b +: 8] = AD[8*b +: 8];
          tph++;
        end
      end else begin
        DEVSEL = 1'b1; TRDY = 1'b1; tgt_oe = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0; RST = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1; tgt_oe = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] wd4;
    logic [31:0]  want4 [4];
    bit           wr;
    int           len, dl, rst_at;
    logic [31:0]  addr;
    logic [15:0]  waits;

    for (int i = 0; i < 4; i++) begin
      mmem[i] = '0;
      tgt_mem[i] = '0;
    end
    want4[0] = 32'd0; want4[1] = 32'd1002; want4[2] = 32'd0; want4[3] = 32'd1004;
    wd4 = {32'd1004, 32'd1003, 32'd1002, 32'd1001};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_Frame_IRDY", {30'd0, Frame, IRDY}, 32'd3);
    RST = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    clear_obs();
    run_txn(1'b1, 32'h10, 3, 16'h0F0F, wd4, 0, 16'h0000, 0, -1, 1'b0);
    chk("wr4_busy", 32'(obs_busy), 32'd6);
    chk("wr4_done", 32'(obs_done), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("wr4_tgt_mem", tgt_mem[i], want4[i]);
      chk("wr4_model_mem", mmem[i], want4[i]);
    end

    clear_obs();
    run_txn(1'b0, 32'h10, 3, 16'h0000, '0, 0, 16'h0001, 0, -1, 1'b0);
    chk("rd4_rdv", 32'(obs_rdv), 32'd4);
    chk("rd4_busy", 32'(obs_busy), 32'd7);
    for (int i = 0; i < 4; i++) chk("rd4_data", (i < rd_obs.size()) ? rd_obs[i] : 32'hDEAD_BEEF, want4[i]);

    clear_obs();
    run_txn(1'b0, 32'h10, 3, 16'h0000, '0, 0, 16'h0201, 0, -1, 1'b0);
    chk("rdwait_rdv", 32'(obs_rdv), 32'd4);
    chk("rdwait_busy", 32'(obs_busy), 32'd9);

    clear_obs();
    run_txn(1'b0, 32'h20, 3, 16'h0000, '0, 0, 16'h0000, 0, -1, 1'b0);
    chk("abort_pulse", 32'(obs_abort), 32'd1);
    chk("abort_rdv", 32'(obs_rdv), 32'd0);
    chk("abort_busy", 32'(obs_busy), 32'd8);

    clear_obs();
    run_txn(1'b1, 32'h18, 0, 16'h0000, {96'd0, 32'hA5A5_5A5A}, 0, 16'h0000, 0, -1, 1'b0);
    chk("single_busy", 32'(obs_busy), 32'd3);

    clear_obs();
    run_txn(1'b1, 32'h20, 0, 16'h0000, {96'd0, 32'h1234_5678}, 0, 16'h0000, TO, -1, 1'b0);
    chk("tie_done", 32'(obs_done), 32'd1);
    chk("tie_abort", 32'(obs_abort), 32'd0);

    clear_obs();
    run_txn(1'b1, 32'h14, 3, 16'h0000, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 16'h0000, 0, 3, 1'b0);
    chk("rst_done", 32'(obs_done), 32'd0);
    clear_obs();
    run_txn(1'b1, 32'h1C, 0, 16'h0000, {96'd0, 32'h7777_0001}, 0, 16'h0000, 0, -1, 1'b0);
    chk("after_rst_busy", 32'(obs_busy), 32'd3);

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom % 2);
      addr = (($urandom % 8) != 0) ? 32'h10 + 4 * ($urandom % 4) : 32'h20 + 4 * ($urandom % 4);
      len = int'($urandom % 4);
      dl = int'($urandom % TO);
      waits = '0;
      for (int i = 0; i < 4; i++) waits[4*i +: 4] = 4'($urandom % 3);
      rst_at = (addr < 32'h20 && ($urandom % 8) == 0) ? 1 : -1;
      run_txn(wr, addr, len, 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
              dl, waits, 0, rst_at, 1'b1);
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("final_mem", tgt_mem[i], mmem[i]);
    chk("trace_drained", 32'(exp_map.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
